// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor switching at period boundaries.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge term giving 50% duty for odd divisors.
module clk_div_prog #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic             clk_rx,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] div_n,
    input  logic             div_load,
    output logic             div_ack,
    output logic             err,
    output logic             clk_tx,
    output logic             tick,
    output logic [WIDTH-1:0] phase_gray
);

    localparam logic [WIDTH-1:0] LP_DIV_RST  = WIDTH'(DIV_RST);
    localparam logic [WIDTH-1:0] LP_CNT_RST  = WIDTH'(DIV_RST - 1);
    localparam logic [WIDTH-1:0] LP_GRAY_RST = LP_CNT_RST ^ (LP_CNT_RST >> 1);
    localparam logic [WIDTH-1:0] LP_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_MIN_DIV  = WIDTH'(2);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_clk_hi;
    logic             r_tick;
    logic             r_div_ack;
    logic             r_err;
    logic [WIDTH-1:0] r_phase_gray;

    logic             w_wrap;
    logic             w_apply;
    logic             w_load_ok;
    logic             w_load_bad;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_div_next;

    // Next phase and divisor; a pending divisor only takes over on the wrap edge.
    always_comb begin
        w_wrap     = (r_cnt == (r_div_q - LP_ONE));
        w_apply    = w_wrap & r_pend_valid;
        w_cnt_next = w_wrap ? '0 : (r_cnt + LP_ONE);
        w_div_next = w_apply ? r_pend : r_div_q;
        w_load_ok  = div_load & (div_n >= LP_MIN_DIV);
        w_load_bad = div_load & (div_n < LP_MIN_DIV);
    end

    always_ff @(posedge clk_rx) begin
        if (!rst_n) begin
            r_cnt        <= LP_CNT_RST;
            r_div_q      <= LP_DIV_RST;
            r_pend       <= LP_DIV_RST;
            r_pend_valid <= 1'b0;
            r_clk_hi     <= 1'b0;
            r_tick       <= 1'b0;
            r_div_ack    <= 1'b0;
            r_err        <= 1'b0;
            r_phase_gray <= LP_GRAY_RST;
        end else begin
            r_cnt        <= w_cnt_next;
            r_div_q      <= w_div_next;
            r_clk_hi     <= (w_cnt_next < (w_div_next >> 1));
            r_tick       <= (w_cnt_next == '0);
            r_div_ack    <= w_apply;
            r_phase_gray <= w_cnt_next ^ (w_cnt_next >> 1);
            // A load sampled on the wrap edge stays pending for the next wrap.
            if (w_load_ok) begin
                r_pend       <= div_n;
                r_pend_valid <= 1'b1;
                r_err        <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_pend_valid <= 1'b0;
                end
                if (w_load_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic r_clk_hi_neg;

    // Half-cycle delayed copy of the high term stretches odd-N high time by half a cycle.
    always_ff @(negedge clk_rx) begin
        if (!rst_n) begin
            r_clk_hi_neg <= 1'b0;
        end else begin
            r_clk_hi_neg <= r_clk_hi;
        end
    end

    assign clk_tx = r_div_q[0] ? (r_clk_hi | r_clk_hi_neg) : r_clk_hi;
`else
    assign clk_tx = r_clk_hi;
`endif

    assign div_ack    = r_div_ack;
    assign err        = r_err;
    assign tick       = r_tick;
    assign phase_gray = r_phase_gray;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random loads/resets
// against a period-position reference model.
module tb_clk_div_prog;

    localparam int W       = 8;
    localparam int DIV_RST = 2;

    logic         clk_rx = 1'b0;
    logic         rst_n  = 1'b0;
    logic [W-1:0] div_n  = '0;
    logic         div_load = 1'b0;
    logic         div_ack;
    logic         err;
    logic         clk_tx;
    logic         tick;
    logic [W-1:0] phase_gray;

    clk_div_prog #(.WIDTH(W), .DIV_RST(DIV_RST)) dut (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .div_n      (div_n),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .err        (err),
        .clk_tx     (clk_tx),
        .tick       (tick),
        .phase_gray (phase_gray)
    );

    always #5 clk_rx = ~clk_rx;

    int errors = 0;
    int checks = 0;

    // Reference model: active divisor, position within the current period, pending request.
    int m_n, m_p, m_pend;
    bit m_pv, m_err, m_ack, m_hi, m_prev_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input int n);
        bit wrap;
        logic [31:0] exp_clk;
        rst_n    = ~rst;
        div_load = ld;
        div_n    = W'(n);
        @(posedge clk_rx);
        #1;
        rst_n    = 1'b1;
        div_load = 1'b0;
        m_prev_hi = m_hi;
        if (rst) begin
            m_n = DIV_RST; m_p = DIV_RST - 1; m_pv = 0; m_err = 0; m_ack = 0; m_prev_hi = 0;
        end else begin
            wrap  = (m_p == m_n - 1);
            m_ack = wrap && m_pv;
            if (wrap) begin
                m_p = 0;
                if (m_pv) begin m_n = m_pend; m_pv = 0; end
            end else begin
                m_p++;
            end
            if (ld) begin
                if (n >= 2) begin m_pend = n; m_pv = 1; m_err = 0; end
                else m_err = 1;
            end
        end
        m_hi = (m_p < m_n / 2);
`ifdef CLK_DIV_ODD_DUTY50_EN
        exp_clk = 32'(m_hi | ((m_n % 2 == 1) && m_prev_hi));
`else
        exp_clk = 32'(m_hi);
`endif
        chk("clk_tx", 32'(clk_tx), exp_clk);
        chk("tick", 32'(tick), 32'(m_p == 0));
        chk("phase_gray", 32'(phase_gray), 32'(m_p ^ (m_p >> 1)));
        chk("div_ack", 32'(div_ack), 32'(m_ack));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // Waits (bounded) for a tick, then counts clk_tx-high samples over one period.
    task automatic measure_high(input string tag, input int period, input int exp_hi);
        int k;
        int hi;
        k = 0;
        while (tick !== 1'b1 && k < 300) begin step(0, 0, 0); k++; end
        chk({tag, "_tick_wait"}, 32'(k < 300), 32'd1);
        hi = 0;
        for (int i = 0; i < period; i++) begin
            if (clk_tx === 1'b1) hi++;
            step(0, 0, 0);
        end
        chk({tag, "_high_cycles"}, 32'(hi), 32'(exp_hi));
        chk({tag, "_next_tick"}, 32'(tick), 32'd1);
    endtask

    initial begin
        int acks;
        int k;
        m_n = DIV_RST; m_p = DIV_RST - 1; m_pend = DIV_RST; m_hi = 0;

        // Reset, then divide-by-2 out of reset
        repeat (3) step(1, 0, 0);
        repeat (8) step(0, 0, 0);

        // N=12 loaded mid-period
        step(0, 0, 0);
        step(0, 1, 12);
        repeat (4) step(0, 0, 0);
        measure_high("n12", 12, 6);
        repeat (12) step(0, 0, 0);

        // N=9 odd divisor
        step(0, 1, 9);
`ifdef CLK_DIV_ODD_DUTY50_EN
        measure_high("n9", 9, 5);
`else
        measure_high("n9", 9, 4);
`endif
        measure_high("n9b", 9, 4 + ((m_n == 9) ? 0 : 0) + 0 `ifdef CLK_DIV_ODD_DUTY50_EN + 1 `endif);

        // Last-wins pending: 80 then 3 before the wrap, single ack
        step(0, 1, 80);
        step(0, 1, 3);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (div_ack === 1'b1) acks++;
        end
        chk("single_ack", 32'(acks), 32'd1);
        chk("divisor_three_tick_period", 32'(m_n), 32'd3);

        // Illegal divisor sets err and keeps the divisor, legal load clears err
        step(0, 1, 1);
        repeat (6) step(0, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 4);
        repeat (10) step(0, 0, 0);

        // Load sampled exactly on a wrap edge applies one period later
        k = 0;
        while (m_p != m_n - 1 && k < 100) begin step(0, 0, 0); k++; end
        chk("wrap_align", 32'(k < 100), 32'd1);
        step(0, 1, 6);
        chk("wrap_load_not_applied", 32'(div_ack), 32'd0);
        repeat (14) step(0, 0, 0);

        // Reset mid-period with a pending N=9 discards it
        step(0, 1, 9);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);

        // Random loads (including illegal) with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/divisor width in bits.
REQ-002 SHALL have parameter DIV_RST, default 2, divisor active out of reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk_rx  input  1  source clock; all state updates on posedge clk_rx, except the half-cycle flop of REQ-026.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port div_n  input  WIDTH  requested divisor N.
REQ-006 SHALL have port div_load  input  1  one-cycle request to apply div_n.
REQ-007 SHALL have port div_ack  output  1  one-cycle pulse when a new divisor takes effect.
REQ-008 SHALL have port err  output  1  sticky flag, set on an illegal divisor request.
REQ-009 SHALL have port clk_tx  output  1  divided clock.
REQ-010 SHALL have port tick  output  1  one-cycle pulse at each clk_tx period start.
REQ-011 SHALL have port phase_gray  output  WIDTH  Gray-coded phase count.

Function
REQ-012 SHALL hold an active divisor div_q and a phase counter cnt; div_q resets to DIV_RST.
REQ-013 SHALL set cnt_next to 0 when cnt == div_q-1, else to cnt+1 (the wrap edge).
REQ-014 SHALL register clk_tx <= (cnt_next < floor(div_q/2)) on every active edge; duty is exactly 50% for even N.
REQ-015 SHALL register tick <= (cnt_next == 0); tick is coincident with the first high cycle of clk_tx.
REQ-016 SHALL register phase_gray <= cnt_next ^ (cnt_next >> 1); adjacent values, including the wrap, differ in one bit only when N is a power of two.
REQ-017 SHALL sample div_load on each active edge; if div_n >= 2, store div_n in a pending register, set pend_valid and clear err.
REQ-018 SHALL reject any div_load with div_n < 2: set err, leave the pending register and pend_valid unchanged.
REQ-019 SHALL, on a wrap edge with pend_valid=1 (value before that edge), copy pending to div_q, clear pend_valid and pulse div_ack with tick; the new period uses the new N from cnt=0.
REQ-020 SHALL treat a legal div_load on a wrap edge as pending for the following wrap; it is never applied on the edge where it is sampled.
REQ-021 SHALL let multiple legal loads before a wrap overwrite pending (last wins), giving exactly one div_ack.
REQ-022 SHALL never glitch clk_tx or truncate a period on divisor change; switching happens only at period boundaries.

Reset
REQ-023 SHALL, on an active edge with rst_n=0, set cnt=DIV_RST-1, div_q=DIV_RST, clk_tx=0, tick=0, div_ack=0, err=0, pend_valid=0 and phase_gray=gray(DIV_RST-1).
REQ-024 SHALL give rst_n priority over div_load; a reset mid-period or with a pending load discards all in-flight state.
REQ-025 SHALL make the first active edge after reset release a wrap edge: clk_tx rises and tick pulses on that edge.

Configuration
REQ-026 SHALL honour macro CLK_DIV_ODD_DUTY50_EN: when defined, a negedge clk_rx flop (reset synchronously by rst_n on negedge) delays the posedge high term by half a cycle, and for odd N clk_tx is the OR of both terms; high time = N/2 clk_rx periods.
REQ-027 SHALL, without CLK_DIV_ODD_DUTY50_EN, contain no negedge logic; for odd N clk_tx is high floor(N/2) and low ceil(N/2) cycles; even N is identical in both builds.

Verification
REQ-028 SHALL cover: WIDTH=8, DIV_RST=2, reset release -> clk_tx toggles every edge, tick on every second edge, phase_gray alternates 00/01.
REQ-029 SHALL cover: load N=12 mid-period -> div_ack with the next tick, then clk_tx 6 high/6 low, phase_gray steps 0..11 in Gray code.
REQ-030 SHALL cover: load N=9 with macro undefined -> 4 high/5 low; with macro defined -> high 4.5 cycles, period 9 cycles.
REQ-031 SHALL cover: load N=80 then N=3 before the wrap -> only N=3 applied, single div_ack; load N=1 -> err=1 and divisor unchanged; a later legal load clears err.
REQ-032 SHALL cover: load on a wrap edge -> applied one period later; rst_n low mid-period with pending N=9 -> REQ-023 values, pending discarded, period=2 after release.
